// File: rtl/secded_byte_assembler.sv
// Pairs decoded Hamming(8,4) nibbles back into bytes, merges the error flags,
// and presents each byte through a one-deep valid/ready output register.
module secded_byte_assembler #(
    parameter int CNT_W     = 16,
    parameter int LOW_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             nib_valid,
    input  logic [3:0]       nib_data,
    input  logic             nib_corrected,
    input  logic             nib_double,
    input  logic             resync,
    input  logic             clr_counts,
    output logic             byte_valid,
    input  logic             byte_ready,
    output logic [7:0]       byte_data,
    output logic             byte_corrected,
    output logic             byte_double,
    output logic             overrun,
    output logic [CNT_W-1:0] corr_count,
    output logic [CNT_W-1:0] dbl_count
);

    typedef enum logic {WAIT_FIRST, WAIT_SECOND} state_t;

    state_t           state_q, state_d;
    logic [3:0]       hold_data_q, hold_data_d;
    logic             hold_corr_q, hold_corr_d;
    logic             hold_dbl_q, hold_dbl_d;
    logic             out_valid_q, out_valid_d;
    logic [7:0]       out_data_q, out_data_d;
    logic             out_corr_q, out_corr_d;
    logic             out_dbl_q, out_dbl_d;
    logic             overrun_q, overrun_d;
    logic [CNT_W-1:0] corr_cnt_q, corr_cnt_d;
    logic [CNT_W-1:0] dbl_cnt_q, dbl_cnt_d;

    logic             byte_done;
    logic [7:0]       asm_data;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            return v;
        end
        return v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    always_comb begin
        state_d     = state_q;
        hold_data_d = hold_data_q;
        hold_corr_d = hold_corr_q;
        hold_dbl_d  = hold_dbl_q;
        byte_done   = 1'b0;

        // A resync coinciding with a strobe restarts pairing on that strobe.
        if (nib_valid) begin
            if (resync || state_q == WAIT_FIRST) begin
                hold_data_d = nib_data;
                hold_corr_d = nib_corrected;
                hold_dbl_d  = nib_double;
                state_d     = WAIT_SECOND;
            end else begin
                byte_done = 1'b1;
                state_d   = WAIT_FIRST;
            end
        end else if (resync) begin
            hold_data_d = 4'h0;
            hold_corr_d = 1'b0;
            hold_dbl_d  = 1'b0;
            state_d     = WAIT_FIRST;
        end

        if (LOW_FIRST != 0) begin
            asm_data = {nib_data, hold_data_q};
        end else begin
            asm_data = {hold_data_q, nib_data};
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_corr_d  = out_corr_q;
        out_dbl_d   = out_dbl_q;
        overrun_d   = 1'b0;

        if (byte_done && (!out_valid_q || byte_ready)) begin
            out_valid_d = 1'b1;
            out_data_d  = asm_data;
            out_corr_d  = hold_corr_q | nib_corrected;
            out_dbl_d   = hold_dbl_q | nib_double;
        end else if (byte_done) begin
            overrun_d = 1'b1;
        end else if (out_valid_q && byte_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_comb begin
        corr_cnt_d = corr_cnt_q;
        dbl_cnt_d  = dbl_cnt_q;
        if (clr_counts) begin
            corr_cnt_d = '0;
            dbl_cnt_d  = '0;
        end else begin
            if (nib_valid && nib_corrected) begin
                corr_cnt_d = sat_inc(corr_cnt_q);
            end
            if (nib_valid && nib_double) begin
                dbl_cnt_d = sat_inc(dbl_cnt_q);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= WAIT_FIRST;
            hold_data_q <= 4'h0;
            hold_corr_q <= 1'b0;
            hold_dbl_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= 8'h00;
            out_corr_q  <= 1'b0;
            out_dbl_q   <= 1'b0;
            overrun_q   <= 1'b0;
            corr_cnt_q  <= '0;
            dbl_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            hold_data_q <= hold_data_d;
            hold_corr_q <= hold_corr_d;
            hold_dbl_q  <= hold_dbl_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_corr_q  <= out_corr_d;
            out_dbl_q   <= out_dbl_d;
            overrun_q   <= overrun_d;
            corr_cnt_q  <= corr_cnt_d;
            dbl_cnt_q   <= dbl_cnt_d;
        end
    end

    assign byte_valid     = out_valid_q;
    assign byte_data      = out_data_q;
    assign byte_corrected = out_corr_q;
    assign byte_double    = out_dbl_q;
    assign overrun        = overrun_q;
    assign corr_count     = corr_cnt_q;
    assign dbl_count      = dbl_cnt_q;

endmodule

// File: tb/tb_secded_byte_assembler.sv
// Randomized and directed checks of two assembler configurations against a
// nibble-pairing reference model kept in this bench.
module tb_secded_byte_assembler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       nib_valid, nib_corrected, nib_double, resync, clr_counts, byte_ready;
    logic [3:0] nib_data;

    logic        a_valid, a_corr, a_dbl, a_ovr;
    logic [7:0]  a_data;
    logic [15:0] a_cc, a_dc;
    logic        b_valid, b_corr, b_dbl, b_ovr;
    logic [7:0]  b_data;
    logic [1:0]  b_cc, b_dc;

    secded_byte_assembler #(.CNT_W(16), .LOW_FIRST(1)) dut_a (
        .clk(clk), .rst(rst), .nib_valid(nib_valid), .nib_data(nib_data),
        .nib_corrected(nib_corrected), .nib_double(nib_double), .resync(resync),
        .clr_counts(clr_counts), .byte_valid(a_valid), .byte_ready(byte_ready),
        .byte_data(a_data), .byte_corrected(a_corr), .byte_double(a_dbl),
        .overrun(a_ovr), .corr_count(a_cc), .dbl_count(a_dc)
    );

    secded_byte_assembler #(.CNT_W(2), .LOW_FIRST(0)) dut_b (
        .clk(clk), .rst(rst), .nib_valid(nib_valid), .nib_data(nib_data),
        .nib_corrected(nib_corrected), .nib_double(nib_double), .resync(resync),
        .clr_counts(clr_counts), .byte_valid(b_valid), .byte_ready(byte_ready),
        .byte_data(b_data), .byte_corrected(b_corr), .byte_double(b_dbl),
        .overrun(b_ovr), .corr_count(b_cc), .dbl_count(b_dc)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: index 0 is dut_a, index 1 is dut_b.
    bit          lowf [2] = '{1'b1, 1'b0};
    int unsigned cmax [2] = '{32'd65535, 32'd3};
    bit          m_have [2];
    logic [3:0]  m_held [2];
    bit          m_hc [2], m_hd [2];
    bit          m_ov [2];
    logic [7:0]  m_data [2];
    bit          m_bc [2], m_bd [2], m_orun [2];
    int unsigned m_cc [2], m_dc [2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_have[k] = 0; m_held[k] = 4'h0; m_hc[k] = 0; m_hd[k] = 0;
            m_ov[k] = 0; m_data[k] = 8'h00; m_bc[k] = 0; m_bd[k] = 0;
            m_orun[k] = 0; m_cc[k] = 0; m_dc[k] = 0;
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            bit         done = 0;
            logic [7:0] nb = 8'h00;
            bit         nc = 0, nd = 0;
            if (nib_valid) begin
                if (resync || !m_have[k]) begin
                    m_have[k] = 1; m_held[k] = nib_data;
                    m_hc[k] = nib_corrected; m_hd[k] = nib_double;
                end else begin
                    done = 1;
                    nb = lowf[k] ? {nib_data, m_held[k]} : {m_held[k], nib_data};
                    nc = m_hc[k] | nib_corrected;
                    nd = m_hd[k] | nib_double;
                    m_have[k] = 0;
                end
            end else if (resync) begin
                m_have[k] = 0;
            end
            m_orun[k] = 0;
            if (done) begin
                if (!m_ov[k] || byte_ready) begin
                    m_ov[k] = 1; m_data[k] = nb; m_bc[k] = nc; m_bd[k] = nd;
                end else begin
                    m_orun[k] = 1;
                end
            end else if (m_ov[k] && byte_ready) begin
                m_ov[k] = 0;
            end
            if (clr_counts) begin
                m_cc[k] = 0; m_dc[k] = 0;
            end else begin
                if (nib_valid && nib_corrected && m_cc[k] < cmax[k]) m_cc[k]++;
                if (nib_valid && nib_double && m_dc[k] < cmax[k]) m_dc[k]++;
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".a_valid"}, 32'(a_valid), 32'(m_ov[0]));
        chk({tag, ".a_data"},  32'(a_data),  32'(m_data[0]));
        chk({tag, ".a_corr"},  32'(a_corr),  32'(m_bc[0]));
        chk({tag, ".a_dbl"},   32'(a_dbl),   32'(m_bd[0]));
        chk({tag, ".a_ovr"},   32'(a_ovr),   32'(m_orun[0]));
        chk({tag, ".a_cc"},    32'(a_cc),    m_cc[0]);
        chk({tag, ".a_dc"},    32'(a_dc),    m_dc[0]);
        chk({tag, ".b_valid"}, 32'(b_valid), 32'(m_ov[1]));
        chk({tag, ".b_data"},  32'(b_data),  32'(m_data[1]));
        chk({tag, ".b_corr"},  32'(b_corr),  32'(m_bc[1]));
        chk({tag, ".b_dbl"},   32'(b_dbl),   32'(m_bd[1]));
        chk({tag, ".b_ovr"},   32'(b_ovr),   32'(m_orun[1]));
        chk({tag, ".b_cc"},    32'(b_cc),    m_cc[1]);
        chk({tag, ".b_dc"},    32'(b_dc),    m_dc[1]);
    endtask

    task automatic step(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic send(input string tag, input logic [3:0] d, input bit c, input bit dd);
        nib_valid = 1; nib_data = d; nib_corrected = c; nib_double = dd;
        step(tag);
        nib_valid = 0; nib_corrected = 0; nib_double = 0;
    endtask

    initial begin
        rst = 0; nib_valid = 0; nib_data = 4'h0; nib_corrected = 0; nib_double = 0;
        resync = 0; clr_counts = 0; byte_ready = 1;
        model_reset();
        #1 rst = 1;
        #1 check_all("reset");
        @(posedge clk); #1 rst = 0;

        // Clean path
        send("clean0", 4'h5, 0, 0);
        send("clean1", 4'hA, 0, 0);
        chk("clean.a_byte", 32'(a_data), 32'h0A5);
        chk("clean.b_byte", 32'(b_data), 32'h05A);
        chk("clean.a_valid", 32'(a_valid), 32'd1);
        step("clean_idle");
        chk("clean.a_valid_drop", 32'(a_valid), 32'd0);

        // Flag merge and counters
        send("flag0", 4'h3, 1, 0);
        send("flag1", 4'hC, 0, 1);
        chk("flag.a_byte", 32'(a_data), 32'h0C3);
        chk("flag.a_corr", 32'(a_corr), 32'd1);
        chk("flag.a_dbl",  32'(a_dbl),  32'd1);
        chk("flag.a_cc",   32'(a_cc),   32'd1);
        chk("flag.a_dc",   32'(a_dc),   32'd1);
        step("flag_idle");

        // Back-pressure and overrun
        byte_ready = 0;
        send("bp0", 4'h1, 0, 0);
        send("bp1", 4'h1, 0, 0);
        chk("bp.a_first", 32'(a_data), 32'h011);
        send("bp2", 4'h2, 0, 0);
        send("bp3", 4'h2, 0, 0);
        chk("bp.a_overrun", 32'(a_ovr), 32'd1);
        chk("bp.a_hold", 32'(a_data), 32'h011);
        step("bp_idle");
        chk("bp.a_overrun_pulse", 32'(a_ovr), 32'd0);
        byte_ready = 1;
        step("bp_drain");
        chk("bp.a_drained", 32'(a_valid), 32'd0);

        // Resync
        send("rs0", 4'h7, 0, 0);
        resync = 1;
        send("rs1", 4'h1, 0, 0);
        resync = 0;
        send("rs2", 4'h9, 0, 0);
        chk("rs.a_byte", 32'(a_data), 32'h091);
        step("rs_idle");

        // Saturation on the narrow counter instance
        for (int i = 0; i < 5; i++) send("sat", 4'(i), 1, 0);
        chk("sat.b_cc", 32'(b_cc), 32'd3);
        clr_counts = 1;
        send("clr", 4'hE, 1, 0);
        clr_counts = 0;
        chk("clr.b_cc", 32'(b_cc), 32'd0);
        chk("clr.a_cc", 32'(a_cc), 32'd0);

        // Asynchronous reset while a nibble is held
        send("rst_hold", 4'h6, 0, 0);
        rst = 1;
        model_reset();
        #1 check_all("rst_async");
        @(posedge clk); #1 rst = 0;
        send("rst_first", 4'h4, 0, 0);
        chk("rst.no_valid", 32'(a_valid), 32'd0);
        send("rst_second", 4'h8, 0, 0);
        chk("rst.a_byte", 32'(a_data), 32'h084);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            nib_valid     = ($urandom_range(1, 0) == 1);
            nib_data      = 4'($urandom);
            nib_corrected = ($urandom_range(3, 0) == 0);
            nib_double    = ($urandom_range(7, 0) == 0);
            resync        = ($urandom_range(31, 0) == 0);
            clr_counts    = ($urandom_range(63, 0) == 0);
            byte_ready    = ($urandom_range(9, 0) < 7);
            step("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/secded_byte_assembler.md
Name: secded_byte_assembler

Overview:
- Sits directly downstream of the Hamming(8,4) SEC-DED decoder on the UART receive path.
- Collects two consecutive decoded 4-bit nibbles, one per received codeword, and rebuilds the original 8-bit byte.
- Merges the per-nibble corrected/double-error flags and presents the byte on a valid/ready interface to the RX consumer.
- Keeps saturating counters of corrected-nibble and double-error events for status readout.

Parameters:
- CNT_W, 16: width of the corr_count and dbl_count event counters.
- LOW_FIRST, 1: 1 = first nibble received is byte[3:0]; 0 = first nibble received is byte[7:4].

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- nib_valid  in  1  one-cycle strobe, decoded nibble present; no back-pressure, always accepted.
- nib_data  in  4  decoded data nibble from the decoder.
- nib_corrected  in  1  decoder corrected a single-bit error in this codeword.
- nib_double  in  1  decoder detected an uncorrectable double-bit error in this codeword.
- resync  in  1  drop any held first nibble; realign the pairing.
- clr_counts  in  1  synchronous clear of both counters.
- byte_valid  out  1  output byte available.
- byte_ready  in  1  consumer accepts the byte.
- byte_data  out  8  assembled byte.
- byte_corrected  out  1  OR of the two nibbles' corrected flags.
- byte_double  out  1  OR of the two nibbles' double flags.
- overrun  out  1  one-cycle pulse: completed byte dropped because the output register was full.
- corr_count  out  CNT_W  saturating count of nib_corrected events.
- dbl_count  out  CNT_W  saturating count of nib_double events.

Behaviour:
- Reset (rst=1, asynchronous): state=WAIT_FIRST; held nibble and flags cleared; byte_valid=0, byte_data=0, byte_corrected=0, byte_double=0, overrun=0, corr_count=0, dbl_count=0.
- State machine, two states: WAIT_FIRST and WAIT_SECOND.
- WAIT_FIRST with nib_valid=1: latch nib_data, nib_corrected and nib_double into hold registers; go to WAIT_SECOND.
- WAIT_SECOND with nib_valid=1: form the byte.
  - LOW_FIRST=1: byte = {nib_data, held}.
  - LOW_FIRST=0: byte = {held, nib_data}.
  - Each flag = held flag OR incoming flag.
  - Go to WAIT_FIRST.
- Output register (one deep):
  - Loaded when empty (byte_valid=0), or when draining in the same cycle (byte_valid=1 and byte_ready=1).
  - After a load, byte_valid=1 on the next cycle. Latency: second nib_valid to byte_valid is 1 cycle.
  - Full and not draining when a byte completes: the new byte is discarded; overrun=1 for exactly one cycle; the register contents are unchanged.
  - byte_valid=1 and byte_ready=1 with no load: byte_valid=0 on the next cycle.
  - byte_data and both flags are held stable while byte_valid=1 and byte_ready=0.
- Double errors: the byte is still delivered, with byte_double=1; data bits are passed through uncorrected.
- resync=1: held nibble discarded; state forced to WAIT_FIRST.
  - resync and nib_valid in the same cycle: the incoming nibble is latched as the first nibble and state=WAIT_SECOND.
  - resync has no effect on the output register.
- Counters:
  - corr_count increments by 1 on each cycle with nib_valid=1 and nib_corrected=1.
  - dbl_count increments by 1 on each cycle with nib_valid=1 and nib_double=1.
  - Both saturate at 2^CNT_W-1; no wrap.
  - clr_counts=1 forces both counters to 0 and has priority over a same-cycle increment.
  - Nibbles are counted even if their byte is later dropped by overrun or resync.
- Inputs sampled only when nib_valid=1. nib_corrected and nib_double both 1 in the same nibble: both flags and both counters are updated.

Test Plan:
- Reset mid-operation: hold one nibble, assert rst -> all outputs 0 immediately; next nibble 0x4 is treated as the first nibble, with no byte_valid.
- LOW_FIRST=1, clean path: nib 0x5 then 0xA, byte_ready=1 -> byte_data=0xA5, byte_valid=1 for one cycle, one cycle after the second strobe; flags 0; counters 0.
- Flag merge and counters: nib 0x3 with corrected=1, then 0xC with double=1 -> byte_data=0xC3, byte_corrected=1, byte_double=1; corr_count=1, dbl_count=1.
- Back-pressure and overrun: byte_ready=0; send 0x11 then 0x22 (four nibbles) -> first byte 0x11 held stable; overrun pulses once when the second byte completes; byte_ready=1 -> 0x11 delivered, then byte_valid=0.
- Resync: nib 0x7, then resync together with nib 0x1, then nib 0x9 -> byte_data=0x91; 0x7 is never output.
- Counter saturation: CNT_W=2; five corrected nibbles -> corr_count stays at 3; clr_counts asserted with a corrected nibble in the same cycle -> corr_count=0.
